// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB refill walker: exception codes, PTE layout,
// address field widths and the walk FSM encoding.
package tlb_pkg;

    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBL = 5'd2;
    localparam logic [4:0] EXC_TLBS = 5'd3;

    localparam int PTE_PPN_MSB = 31;
    localparam int PTE_PPN_LSB = 12;
    localparam int PTE_V_BIT   = 1;
    localparam int PTE_D_BIT   = 0;

    localparam int VPN_W    = 20;
    localparam int PPN_W    = 20;
    localparam int OFFSET_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MREQ,
        ST_MWAIT,
        ST_WRITE,
        ST_RESP
    } walk_state_t;

    // Single-level table: one 4-byte PTE per virtual page, wrapping modulo 2^32.
    function automatic logic [31:0] pte_addr(input logic [31:0] base, input logic [31:0] vaddr);
        return base + {vaddr[31:OFFSET_W], 2'b00};
    endfunction

endpackage

// File: rtl/tlb_repl_ptr.sv
// Round-robin TLB replacement pointer; advances by one entry per successful refill.
module tlb_repl_ptr #(
    parameter int NUM_ENTRIES = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           adv,
    output logic [$clog2(NUM_ENTRIES)-1:0] ptr
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);

    logic [IDX_W-1:0] ptr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (adv) begin
            ptr_reg <= (ptr_reg == IDX_W'(NUM_ENTRIES - 1)) ? '0 : ptr_reg + 1'b1;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/tlb_refill_walker.sv
// TLB miss refill engine: reads one PTE from a single-level page table, writes the
// translation into the TLB round-robin, and reports completion or a TLBL/TLBS fault.
module tlb_refill_walker
    import tlb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int NUM_ENTRIES    = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [31:0]                    req_vaddr,
    input  logic                           req_is_store,
    input  logic [31:0]                    pt_base,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic [31:0]                    mem_addr,
    input  logic                           mem_rvalid,
    input  logic [31:0]                    mem_rdata,
    output logic                           tlb_we,
    output logic [$clog2(NUM_ENTRIES)-1:0] tlb_widx,
    output logic [VPN_W-1:0]               tlb_wvpn,
    output logic [PPN_W-1:0]               tlb_wppn,
    output logic                           tlb_wv,
    output logic                           tlb_wd,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic                           resp_fault,
    output logic [4:0]                     resp_code,
    output logic [31:0]                    resp_badvaddr
);

    localparam int IDX_W = $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    walk_state_t      state_reg, state_next;
    logic [31:0]      vaddr_reg;
    logic [31:0]      mem_addr_reg;
    logic             is_store_reg;
    logic [PPN_W-1:0] ppn_reg;
    logic             dirty_reg;
    logic             fault_reg;
    logic [4:0]       code_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             timeout_hit;
    logic             pte_valid;
    logic [4:0]       fault_code;
    logic [IDX_W-1:0] repl_ptr;
    logic             unused_pte_bits;

    assign cnt_next        = cnt_reg + 1'b1;
    assign timeout_hit     = (cnt_next == CNT_W'(TIMEOUT_CYCLES - 1));
    assign pte_valid       = mem_rdata[PTE_V_BIT];
    assign fault_code      = is_store_reg ? EXC_TLBS : EXC_TLBL;
    assign unused_pte_bits = ^mem_rdata[PTE_PPN_LSB-1:PTE_V_BIT+1];

    tlb_repl_ptr #(
        .NUM_ENTRIES(NUM_ENTRIES)
    ) u_repl_ptr (
        .clk  (clk),
        .reset(reset),
        .adv  (state_reg == ST_WRITE),
        .ptr  (repl_ptr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (req_valid) state_next = ST_MREQ;
            ST_MREQ:  if (mem_req_ready) state_next = ST_MWAIT;
            ST_MWAIT: begin
                // Data arriving in the timeout cycle takes priority over the abort.
                if (mem_rvalid) begin
                    state_next = pte_valid ? ST_WRITE : ST_RESP;
                end else if (timeout_hit) begin
                    state_next = ST_RESP;
                end
            end
            ST_WRITE: state_next = ST_RESP;
            ST_RESP:  if (resp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vaddr_reg    <= '0;
            mem_addr_reg <= '0;
            is_store_reg <= 1'b0;
            ppn_reg      <= '0;
            dirty_reg    <= 1'b0;
            fault_reg    <= 1'b0;
            code_reg     <= '0;
            cnt_reg      <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        vaddr_reg    <= req_vaddr;
                        is_store_reg <= req_is_store;
                        mem_addr_reg <= pte_addr(pt_base, req_vaddr);
                        fault_reg    <= 1'b0;
                        code_reg     <= '0;
                    end
                end
                ST_MREQ: begin
                    if (mem_req_ready) cnt_reg <= '0;
                end
                ST_MWAIT: begin
                    cnt_reg <= cnt_next;
                    if (mem_rvalid) begin
                        ppn_reg   <= mem_rdata[PTE_PPN_MSB:PTE_PPN_LSB];
                        dirty_reg <= mem_rdata[PTE_D_BIT];
                        if (!pte_valid) begin
                            fault_reg <= 1'b1;
                            code_reg  <= fault_code;
                        end
                    end else if (timeout_hit) begin
                        fault_reg <= 1'b1;
                        code_reg  <= fault_code;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready     = (state_reg == ST_IDLE);
        mem_req_valid = (state_reg == ST_MREQ);
        resp_valid    = (state_reg == ST_RESP);
        tlb_we        = 1'b0;
        tlb_widx      = '0;
        tlb_wvpn      = '0;
        tlb_wppn      = '0;
        tlb_wv        = 1'b0;
        tlb_wd        = 1'b0;
        if (state_reg == ST_WRITE) begin
            tlb_we   = 1'b1;
            tlb_widx = repl_ptr;
            tlb_wvpn = vaddr_reg[31:OFFSET_W];
            tlb_wppn = ppn_reg;
            tlb_wv   = 1'b1;
            tlb_wd   = dirty_reg;
        end
    end

    assign mem_addr      = mem_addr_reg;
    assign resp_fault    = fault_reg;
    assign resp_code     = code_reg;
    assign resp_badvaddr = vaddr_reg;

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Directed bench for tlb_refill_walker: table of single walks plus hand-written
// backpressure, timeout and mid-walk reset sequences.
module tb_tlb_refill_walker;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_vaddr;
    logic        req_is_store;
    logic [31:0] pt_base;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        tlb_we;
    logic [1:0]  tlb_widx;
    logic [19:0] tlb_wvpn;
    logic [19:0] tlb_wppn;
    logic        tlb_wv;
    logic        tlb_wd;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_fault;
    logic [4:0]  resp_code;
    logic [31:0] resp_badvaddr;

    always #5 clk = ~clk;

    tlb_refill_walker dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_vaddr    (req_vaddr),
        .req_is_store (req_is_store),
        .pt_base      (pt_base),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr     (mem_addr),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .tlb_we       (tlb_we),
        .tlb_widx     (tlb_widx),
        .tlb_wvpn     (tlb_wvpn),
        .tlb_wppn     (tlb_wppn),
        .tlb_wv       (tlb_wv),
        .tlb_wd       (tlb_wd),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_fault   (resp_fault),
        .resp_code    (resp_code),
        .resp_badvaddr(resp_badvaddr)
    );

    typedef struct {
        logic [31:0] pt_base;
        logic [31:0] vaddr;
        logic        is_store;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [1:0]  exp_idx;
        logic [19:0] exp_vpn;
        logic [19:0] exp_ppn;
        logic        exp_d;
        logic        exp_fault;
        logic [4:0]  exp_code;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    int pass_cnt  = 0;
    int total_cnt = 0;

    int          we_cnt;
    logic [1:0]  cap_idx;
    logic [19:0] cap_vpn;
    logic [19:0] cap_ppn;
    logic        cap_wv;
    logic        cap_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // Advance one cycle and sample just after the edge, recording any TLB write.
    task automatic step();
        @(posedge clk);
        #1;
        if (tlb_we === 1'b1) begin
            we_cnt++;
            cap_idx = tlb_widx;
            cap_vpn = tlb_wvpn;
            cap_ppn = tlb_wppn;
            cap_wv  = tlb_wv;
            cap_wd  = tlb_wd;
        end
    endtask

    task automatic accept(input logic [31:0] base, input logic [31:0] va, input logic st);
        req_valid    = 1'b1;
        req_vaddr    = va;
        req_is_store = st;
        pt_base      = base;
        step();
        req_valid    = 1'b0;
        pt_base      = 32'hDEAD_BEEF;
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int lat;
        we_cnt = 0;
        chk($sformatf("v%0d req_ready_idle", n), {31'd0, req_ready}, 32'd1);
        accept(v.pt_base, v.vaddr, v.is_store);
        chk($sformatf("v%0d mem_req_valid", n), {31'd0, mem_req_valid}, 32'd1);
        chk($sformatf("v%0d mem_addr", n), mem_addr, v.exp_addr);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = v.rdata;
        step();
        mem_rvalid = 1'b0;
        lat = 3;
        while (resp_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk($sformatf("v%0d latency", n), lat, v.exp_lat);
        chk($sformatf("v%0d we_count", n), we_cnt, {31'd0, v.exp_we});
        if (v.exp_we) begin
            chk($sformatf("v%0d widx", n), {30'd0, cap_idx}, {30'd0, v.exp_idx});
            chk($sformatf("v%0d wvpn", n), {12'd0, cap_vpn}, {12'd0, v.exp_vpn});
            chk($sformatf("v%0d wppn", n), {12'd0, cap_ppn}, {12'd0, v.exp_ppn});
            chk($sformatf("v%0d wv", n), {31'd0, cap_wv}, 32'd1);
            chk($sformatf("v%0d wd", n), {31'd0, cap_wd}, {31'd0, v.exp_d});
        end
        chk($sformatf("v%0d resp_fault", n), {31'd0, resp_fault}, {31'd0, v.exp_fault});
        chk($sformatf("v%0d resp_code", n), {27'd0, resp_code}, {27'd0, v.exp_code});
        chk($sformatf("v%0d badvaddr", n), resp_badvaddr, v.vaddr);
        step();
        chk($sformatf("v%0d back_idle", n), {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int n;

        //          pt_base       vaddr         st    rdata         addr          we    idx    vpn       ppn       d     flt   code  lat
        vecs[0] = '{32'h0010_0000, 32'h0000_5123, 1'b0, 32'h0000_7003, 32'h0010_0014, 1'b1, 2'd0, 20'h00005, 20'h00007, 1'b1, 1'b0, 5'd0, 4};
        vecs[1] = '{32'h0020_0000, 32'h1234_5678, 1'b1, 32'hABCD_E002, 32'h0024_8D14, 1'b1, 2'd1, 20'h12345, 20'hABCDE, 1'b0, 1'b0, 5'd0, 4};
        vecs[2] = '{32'h0010_0000, 32'h0000_9000, 1'b1, 32'h0000_1001, 32'h0010_0024, 1'b0, 2'd0, 20'h00000, 20'h00000, 1'b0, 1'b1, 5'd3, 3};
        vecs[3] = '{32'hFFFF_FFF0, 32'h0000_8000, 1'b0, 32'h0FED_C003, 32'h0000_0010, 1'b1, 2'd2, 20'h00008, 20'h0FEDC, 1'b1, 1'b0, 5'd0, 4};
        vecs[4] = '{32'h0000_1000, 32'hFFFF_F000, 1'b0, 32'hFFFF_F001, 32'h0040_0FFC, 1'b0, 2'd0, 20'h00000, 20'h00000, 1'b0, 1'b1, 5'd2, 3};
        vecs[5] = '{32'h0000_0000, 32'h0000_3ABC, 1'b0, 32'h0004_2003, 32'h0000_000C, 1'b1, 2'd3, 20'h00003, 20'h00042, 1'b1, 1'b0, 5'd0, 4};
        vecs[6] = '{32'h0000_0100, 32'h8000_0000, 1'b1, 32'h0000_1002, 32'h0020_0100, 1'b1, 2'd0, 20'h80000, 20'h00001, 1'b0, 1'b0, 5'd0, 4};
        vecs[7] = '{32'h0000_1000, 32'h0000_7000, 1'b0, 32'h0007_7003, 32'h0000_101C, 1'b1, 2'd0, 20'h00007, 20'h00077, 1'b1, 1'b0, 5'd0, 4};

        reset         = 1'b1;
        req_valid     = 1'b0;
        req_vaddr     = '0;
        req_is_store  = 1'b0;
        pt_base       = '0;
        mem_req_ready = 1'b1;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        resp_ready    = 1'b1;
        we_cnt        = 0;
        step();
        step();

        chk("rst req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'd0);
        chk("rst tlb_we", {31'd0, tlb_we}, 32'd0);
        chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst resp_fault_code", {26'd0, resp_fault, resp_code}, 32'd0);
        chk("rst badvaddr", resp_badvaddr, 32'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure on both the memory request and the response.
        we_cnt = 0;
        mem_req_ready = 1'b0;
        accept(32'h0000_0000, 32'h0000_2000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp mreq_valid c%0d", i), {31'd0, mem_req_valid}, 32'd1);
            chk($sformatf("bp mem_addr c%0d", i), mem_addr, 32'h0000_0008);
            step();
        end
        chk("bp mreq_valid held", {31'd0, mem_req_valid}, 32'd1);
        mem_req_ready = 1'b1;
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_5003;
        step();
        mem_rvalid = 1'b0;
        resp_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp resp_valid c%0d", i), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("bp resp_fault_code c%0d", i), {26'd0, resp_fault, resp_code}, 32'd0);
            chk($sformatf("bp badvaddr c%0d", i), resp_badvaddr, 32'h0000_2000);
            chk($sformatf("bp req_ready c%0d", i), {31'd0, req_ready}, 32'd0);
            step();
        end
        chk("bp resp_valid held", {31'd0, resp_valid}, 32'd1);
        resp_ready = 1'b1;
        step();
        chk("bp idle req_ready", {31'd0, req_ready}, 32'd1);
        chk("bp idle resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("bp we_count", we_cnt, 32'd1);
        chk("bp widx", {30'd0, cap_idx}, 32'd1);
        chk("bp wppn", {12'd0, cap_ppn}, 32'h0000_0005);

        // Timeout; rvalid coinciding with the memory handshake must be ignored.
        we_cnt = 0;
        accept(32'h0000_0000, 32'h0000_4000, 1'b0);
        chk("to mem_addr", mem_addr, 32'h0000_0010);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_1003;
        step();
        mem_rvalid = 1'b0;
        n = 1;
        while (resp_valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("to cycles", n, 32'd64);
        chk("to we_count", we_cnt, 32'd0);
        chk("to resp_fault", {31'd0, resp_fault}, 32'd1);
        chk("to resp_code", {27'd0, resp_code}, 32'd2);
        chk("to badvaddr", resp_badvaddr, 32'h0000_4000);
        step();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_9003;
        step();
        mem_rvalid = 1'b0;
        chk("to late req_ready", {31'd0, req_ready}, 32'd1);
        chk("to late mreq_valid", {31'd0, mem_req_valid}, 32'd0);
        step();
        chk("to late we_count", we_cnt, 32'd0);
        chk("to late resp_valid", {31'd0, resp_valid}, 32'd0);

        // Reset while waiting for PTE data abandons the walk and the pointer.
        we_cnt = 0;
        accept(32'h0000_0000, 32'h0000_6000, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mr req_ready", {31'd0, req_ready}, 32'd1);
        chk("mr mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("mr mem_addr", mem_addr, 32'd0);
        chk("mr resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("mr resp_fault_code", {26'd0, resp_fault, resp_code}, 32'd0);
        chk("mr badvaddr", resp_badvaddr, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_6003;
        step();
        mem_rvalid = 1'b0;
        step();
        chk("mr we_count", we_cnt, 32'd0);
        chk("mr idle resp_valid", {31'd0, resp_valid}, 32'd0);
        run_vec(vecs[7], 7);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
